// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist: shifts a key frame into a shadow
// register and commits it atomically to key_p/key_x after a one-cycle CHECK.
// Optional trailing odd-parity bit enabled by defining KEY_PARITY_EN.
module c432_key_loader #(
  parameter int P_W = 4,
  parameter int X_W = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_start,
  input  logic           kin_valid,
  input  logic           kin_data,
  output logic           kin_ready,
  output logic [P_W-1:0] key_p,
  output logic [X_W-1:0] key_x,
  output logic           key_valid,
  output logic           busy,
  output logic           err
);

  localparam int K_W = P_W + X_W;
`ifdef KEY_PARITY_EN
  localparam int N = K_W + 1;
`else
  localparam int N = K_W;
`endif
  localparam logic [4:0] LAST = 5'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [K_W-1:0] key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           err_q, err_d;
  logic           check_ok;

  // Frame acceptance rule: odd parity over the whole frame, or unconditional.
`ifdef KEY_PARITY_EN
  assign check_ok = ^shadow_q;
`else
  assign check_ok = 1'b1;
`endif

  // Next-state logic: load sequencing, bit capture and the atomic commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_SHIFT;
          cnt_d   = 5'd0;
          err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (kin_valid) begin
          shadow_d[cnt_q] = kin_data;
          cnt_d           = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (check_ok) begin
          key_d       = shadow_q[K_W-1:0];
          key_valid_d = 1'b1;
        end else begin
          key_d       = '0;
          key_valid_d = 1'b0;
          err_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      shadow_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  assign kin_ready = (state_q == S_SHIFT);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_CHECK);
  assign key_p     = key_q[P_W-1:0];
  assign key_x     = key_q[K_W-1:P_W];
  assign key_valid = key_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: a frame-level reference model is
// compared against every DUT output on each falling edge, plus literal checks
// of committed keys and commit timing.
module tb_c432_key_loader;

`ifdef KEY_PARITY_EN
  localparam int N = 30;
`else
  localparam int N = 29;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        kin_valid = 1'b0;
  logic        kin_data = 1'b0;
  logic        kin_ready;
  logic [3:0]  key_p;
  logic [24:0] key_x;
  logic        key_valid;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  c432_key_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .kin_valid(kin_valid),
    .kin_data(kin_data), .kin_ready(kin_ready), .key_p(key_p), .key_x(key_x),
    .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the frame being received, the committed key and flags.
  bit          m_loading, m_checking, m_valid, m_err;
  int          m_count;
  logic [29:0] m_frame;
  logic [28:0] m_key;

  function automatic bit frame_ok(input logic [29:0] f);
`ifdef KEY_PARITY_EN
    return (^f) == 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_loading = 0; m_checking = 0; m_valid = 0; m_err = 0;
      m_count = 0; m_frame = '0; m_key = '0;
    end else if (m_checking) begin
      m_checking = 0;
      if (frame_ok(m_frame)) begin
        m_key = m_frame[28:0]; m_valid = 1;
      end else begin
        m_key = '0; m_valid = 0; m_err = 1;
      end
    end else if (m_loading) begin
      if (kin_valid) begin
        m_frame[m_count] = kin_data;
        m_count++;
        if (m_count == N) begin
          m_loading = 0; m_checking = 1;
        end
      end
    end else if (load_start) begin
      m_loading = 1; m_count = 0; m_err = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("key", {3'b0, key_x, key_p}, {3'b0, m_key});
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_loading || m_checking));
      chk("kin_ready", 32'(kin_ready), 32'(m_loading));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Frame with a correct trailing parity bit when parity is enabled.
  function automatic logic [29:0] good(input logic [28:0] d);
    return {~(^d), d};
  endfunction

  // mode: 0 back-to-back, 1 kin_valid every other cycle, 2 random gaps.
  // noise: stray load_start in SHIFT and kin_valid in CHECK/IDLE.
  // abort_after >= 0: apply reset after that many bits have been shifted.
  task automatic load_frame(input logic [29:0] f, input int mode, input bit noise,
                            input int abort_after);
    load_start = 1'b1;
    kin_valid  = noise;
    kin_data   = 1'($urandom);
    step();
    load_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == abort_after) begin
        rst_n = 1'b0; kin_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        return;
      end
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        kin_valid = 1'b0; kin_data = 1'($urandom);
        load_start = noise ? 1'($urandom) : 1'b0;
        step();
      end
      kin_valid  = 1'b1;
      kin_data   = f[i];
      load_start = noise ? 1'($urandom) : 1'b0;
      step();
    end
    load_start = 1'b0;
    chk("busy_in_check", 32'(busy), 32'd1);
    chk("ready_in_check", 32'(kin_ready), 32'd0);
    kin_valid = noise;
    kin_data  = 1'($urandom);
    step();
    chk("busy_after_commit", 32'(busy), 32'd0);
    if (noise) begin
      step(); step();
    end
    kin_valid = 1'b0;
  endtask

  initial begin
    // Reset with load_start and kin_valid held high.
    rst_n = 1'b0; load_start = 1'b1; kin_valid = 1'b1; kin_data = 1'b1;
    step(); step();
    started = 1;
    chk("rst_key", {3'b0, key_x, key_p}, 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(kin_ready), 32'd0);
    load_start = 1'b0; kin_valid = 1'b0; rst_n = 1'b1;
    step();

    // All ones, back-to-back; key_valid must rise exactly at L+1.
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      kin_valid = 1'b1; kin_data = good(29'h1FFFFFFF)[0];
      kin_data = (i < 29) ? 1'b1 : good(29'h1FFFFFFF) >> 29;
      step();
    end
    kin_valid = 1'b0;
    chk("ones_valid_at_L", 32'(key_valid), 32'd0);
    step();
    chk("ones_valid_at_L1", 32'(key_valid), 32'd1);
    chk("ones_key", {3'b0, key_x, key_p}, 32'h1FFFFFFF);
    step();

    // Throttled load of p=1010, X=1.
    load_frame(good({25'h0000001, 4'b1010}), 1, 0, -1);
    chk("thr_p", 32'(key_p), 32'hA);
    chk("thr_x", 32'(key_x), 32'h1);
    // Second key of zero: old key visible until its commit (model checks each cycle).
    load_frame(good(29'h0), 0, 0, -1);
    chk("zero_key", {3'b0, key_x, key_p}, 32'h0);
    chk("zero_valid", 32'(key_valid), 32'd1);

`ifdef KEY_PARITY_EN
    load_frame({1'b1, 29'h0000003}, 0, 0, -1);
    chk("par_ok_key", {3'b0, key_x, key_p}, 32'h3);
    chk("par_ok_err", 32'(err), 32'd0);
    load_frame({1'b0, 29'h0000003}, 0, 0, -1);
    chk("par_bad_valid", 32'(key_valid), 32'd0);
    chk("par_bad_key", {3'b0, key_x, key_p}, 32'h0);
    chk("par_bad_err", 32'(err), 32'd1);
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("par_err_clr", 32'(err), 32'd0);
    load_frame(good(29'h0000005), 0, 0, -1);
    chk("par_reload", {3'b0, key_x, key_p}, 32'h5);
`endif

    // Reset after 10 bits, then reload the full frame.
    load_frame(good(29'h1FFFFFFF), 0, 0, 10);
    chk("abort_valid", 32'(key_valid), 32'd0);
    load_frame(good(29'h15555555), 0, 0, -1);
    chk("reload_key", {3'b0, key_x, key_p}, 32'h15555555);

    // Stray load_start/kin_valid outside their states.
    load_frame(good(29'h0ABCDEF), 2, 1, -1);
    chk("noise_key", {3'b0, key_x, key_p}, 32'h0ABCDEF);

    // Randomized frames, throttling and noise; parity may be good or bad.
    for (int r = 0; r < 12; r++) begin
      logic [29:0] f;
      f = {2'($urandom), 28'($urandom)};
      load_frame(f, int'($urandom_range(0, 2)), 1'($urandom), -1);
      step();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
